cnt_iter: RTL and testbench

- Parametrised, multi-cycle successor to the combinational bit-count unit in the BMU.
- Computes clz, ctz and cpop over CHUNK bits per cycle, with RV64 word-mode support.
- Terminates early for clz/ctz as soon as a chunk containing a 1 is found.
- Intended for area-reduced BMU configurations. Start/Busy/Done handshake to the IEU; Flush from the hazard unit.

---
 rtl/bmu_pkg.sv | 25 ++
 rtl/cnt_chunk.sv | 51 +++++
 rtl/lzc.sv | 30 +++
 rtl/popcnt.sv | 26 ++
 rtl/cnt_iter.sv | 167 ++++++++++++++++
 tb/tb_cnt_iter.sv | 227 ++++++++++++++++++++++
 6 files changed

// File: rtl/bmu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bmu_pkg
// Purpose  : Encodings shared by the BMU decoder and the iterative count unit.
//            cntop_t    - count operation select (CLZ/CTZ/CPOP, 11 reserved)
//            cntstate_t - control states of the iterative counter
// Revision : 1.0 - initial release
// ============================================================================
package bmu_pkg;

  typedef enum logic [1:0] {
    CLZ      = 2'b00,
    CTZ      = 2'b01,
    CPOP     = 2'b10,
    CNT_RSVD = 2'b11   // behaves as CPOP
  } cntop_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } cntstate_t;

endpackage
`default_nettype wire

// File: rtl/cnt_chunk.sv
`default_nettype none
// ============================================================================
// Module   : cnt_chunk
// Purpose  : Per-chunk count for the iterative counter. Returns the leading
//            zero count (CLZ/CTZ; CTZ operands arrive bit-reversed) or the
//            population count (CPOP and the reserved code), plus a flag
//            that the chunk holds at least one set bit.
// Ports    : i_chunk [CHUNK-1:0]       - chunk under examination
//            i_op    [1:0]             - cntop_t operation
//            o_cnt   [$clog2(CHUNK):0] - selected count
//            o_nz                      - chunk is nonzero
// Revision : 1.0 - initial release
// ============================================================================
module cnt_chunk
  import bmu_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]       i_chunk,
  input  logic [1:0]             i_op,
  output logic [$clog2(CHUNK):0] o_cnt,
  output logic                   o_nz
);

  localparam int CNT_W = $clog2(CHUNK) + 1;

  logic [CNT_W-1:0] w_lz;
  logic [CNT_W-1:0] w_pop;
  cntop_t           w_op;

  lzc #(.WIDTH(CHUNK)) u_lzc (
    .i_data (i_chunk),
    .o_cnt  (w_lz)
  );

  popcnt #(.WIDTH(CHUNK)) u_popcnt (
    .i_data (i_chunk),
    .o_cnt  (w_pop)
  );

  always_comb begin
    w_op  = cntop_t'(i_op);
    o_cnt = w_pop;
    if ((w_op == CLZ) || (w_op == CTZ)) begin
      o_cnt = w_lz;
    end
    o_nz = |i_chunk;
  end

endmodule
`default_nettype wire

// File: rtl/lzc.sv
`default_nettype none
// ============================================================================
// Module   : lzc
// Purpose  : Leading-zero count of a WIDTH-bit vector; all-zero input
//            returns WIDTH.
// Ports    : i_data [WIDTH-1:0]        - input vector
//            o_cnt  [$clog2(WIDTH):0]  - number of leading zeros
// Revision : 1.0 - initial release
// ============================================================================
module lzc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]       i_data,
  output logic [$clog2(WIDTH):0] o_cnt
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Ascending scan: the highest set bit is the last to overwrite o_cnt.
  always_comb begin
    o_cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) begin
        o_cnt = CNT_W'(WIDTH - 1 - i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/popcnt.sv
`default_nettype none
// ============================================================================
// Module   : popcnt
// Purpose  : Population count of a WIDTH-bit vector.
// Ports    : i_data [WIDTH-1:0]        - input vector
//            o_cnt  [$clog2(WIDTH):0]  - number of set bits
// Revision : 1.0 - initial release
// ============================================================================
module popcnt #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]       i_data,
  output logic [$clog2(WIDTH):0] o_cnt
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_cnt = o_cnt + CNT_W'(i_data[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cnt_iter.sv
`default_nettype none
// ============================================================================
// Module   : cnt_iter
// Purpose  : Multi-cycle clz/ctz/cpop unit examining CHUNK bits per cycle,
//            with RV64 word-mode (32-bit) support and early termination of
//            clz/ctz at the first nonzero chunk.
// Ports    : clk    - core clock
//            reset  - asynchronous active-high reset
//            Start  - request, accepted in IDLE or DONE when Flush is low
//            Op     - cntop_t: 00 CLZ, 01 CTZ, 10/11 CPOP
//            W64    - word operation (ignored when WIDTH=32)
//            A      - operand, sampled on the accepting edge
//            Flush  - abort; blocks a same-cycle Start
//            Busy   - high while RUN
//            Done   - one-cycle pulse when Result is valid
//            Result - zero-extended count, held until the next Done
// Revision : 1.0 - initial release
// ============================================================================
module cnt_iter
  import bmu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic             W64,
  input  logic [WIDTH-1:0] A,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int ACC_W    = $clog2(WIDTH) + 1;
  localparam int CNT_W    = $clog2(CHUNK) + 1;
  localparam int NCH_FULL = WIDTH / CHUNK;
  localparam int NCH_WORD = 32 / CHUNK;
  localparam int IDX_W    = $clog2(NCH_FULL) + 1;
  // Upper 32 bits set; all ones when WIDTH=32.
  localparam logic [WIDTH-1:0] TOP32_MASK = ~({WIDTH{1'b1}} >> 32);

  cntstate_t        state_q,  state_d;
  logic [WIDTH-1:0] opnd_q,   opnd_d;
  logic [ACC_W-1:0] acc_q,    acc_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  cntop_t           op_q,     op_d;
  logic             word_q,   word_d;
  logic [ACC_W-1:0] result_q, result_d;

  logic             w_word;
  logic             w_accept;
  logic [WIDTH-1:0] w_rev;
  logic [WIDTH-1:0] w_fwd_opnd;
  logic [WIDTH-1:0] w_rev_opnd;
  logic [CHUNK-1:0] w_chunk;
  logic [CNT_W-1:0] w_cnt;
  logic             w_nz;
  logic [IDX_W-1:0] w_last_idx;
  logic             w_fin;

  // Word mode only exists on a 64-bit datapath.
  assign w_word   = W64 && (WIDTH == 64);
  assign w_accept = Start && !Flush;
  assign w_chunk  = opnd_q[WIDTH-1 -: CHUNK];

  // Operand left-justification. A full bit reversal places A[31:0]
  // reversed in the upper half, so word-mode CTZ just masks the lower half.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_rev[i] = A[WIDTH-1-i];
    end
    w_fwd_opnd = w_word ? (A << (WIDTH - 32)) : A;
    w_rev_opnd = w_word ? (w_rev & TOP32_MASK) : w_rev;
  end

  assign w_last_idx = word_q ? IDX_W'(NCH_WORD - 1) : IDX_W'(NCH_FULL - 1);

  cnt_chunk #(.CHUNK(CHUNK)) u_cnt_chunk (
    .i_chunk (w_chunk),
    .i_op    (op_q),
    .o_cnt   (w_cnt),
    .o_nz    (w_nz)
  );

  always_comb begin
    state_d  = state_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    op_d     = op_q;
    word_d   = word_q;
    result_d = result_q;
    w_fin    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (w_accept) begin
          state_d = RUN;
          op_d    = cntop_t'(Op);
          word_d  = w_word;
          opnd_d  = (cntop_t'(Op) == CTZ) ? w_rev_opnd : w_fwd_opnd;
          acc_d   = '0;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (Flush) begin
          state_d = IDLE;
        end else begin
          opnd_d = opnd_q << CHUNK;
          idx_d  = idx_q + IDX_W'(1);
          if ((op_q == CLZ) || (op_q == CTZ)) begin
            if (w_nz) begin
              acc_d = acc_q + ACC_W'(w_cnt);
              w_fin = 1'b1;
            end else begin
              // All-zero operand accumulates to exactly EW at the last chunk.
              acc_d = acc_q + ACC_W'(CHUNK);
              w_fin = (idx_q == w_last_idx);
            end
          end else begin
            acc_d = acc_q + ACC_W'(w_cnt);
            w_fin = (idx_q == w_last_idx);
          end
          if (w_fin) begin
            result_d = acc_d;
            state_d  = DONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      opnd_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      op_q     <= CLZ;
      word_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      word_q   <= word_d;
      result_q <= result_d;
    end
  end

  assign Busy   = (state_q == RUN);
  assign Done   = (state_q == DONE);
  assign Result = {{(WIDTH - ACC_W){1'b0}}, result_q};

endmodule
`default_nettype wire

// File: tb/tb_cnt_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnt_iter
// Purpose  : Self-checking bench for cnt_iter (WIDTH=64, CHUNK=8): directed
//            scenarios plus randomized operations against a bit-level
//            reference model of clz/ctz/cpop and their latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnt_iter;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [1:0]  Op;
  logic        W64;
  logic [63:0] A;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic [63:0] Result;

  int n_vec;
  int n_err;
  int done_cnt;

  cnt_iter #(.WIDTH(64), .CHUNK(8)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .Op     (Op),
    .W64    (W64),
    .A      (A),
    .Flush  (Flush),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (Done === 1'b1) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference count straight from the definitions of clz/ctz/cpop on the
  // effective-width field of A.
  function automatic int ref_res(input logic [1:0] op, input logic w, input logic [63:0] a);
    int ew;
    int n;
    logic stop;
    ew   = w ? 32 : 64;
    n    = 0;
    stop = 1'b0;
    if (op[1]) begin
      for (int i = 0; i < ew; i++) n += int'(a[i]);
    end else if (op == 2'b00) begin
      for (int i = ew - 1; i >= 0; i--) begin
        if (a[i]) stop = 1'b1;
        else if (!stop) n++;
      end
    end else begin
      for (int i = 0; i < ew; i++) begin
        if (a[i]) stop = 1'b1;
        else if (!stop) n++;
      end
    end
    return n;
  endfunction

  // RUN cycles: all chunks for CPOP; for clz/ctz, the chunk holding the
  // first set bit (or all chunks when the operand is zero).
  function automatic int ref_lat(input logic [1:0] op, input logic w, input int n);
    int ew;
    ew = w ? 32 : 64;
    if (op[1]) return ew / 8;
    if (n >= ew) return ew / 8;
    return n / 8 + 1;
  endfunction

  task automatic wait_done(output int busy_n);
    int cyc;
    busy_n = 0;
    cyc    = 0;
    while (Done !== 1'b1 && cyc < 40) begin
      if (Busy === 1'b1) busy_n++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic w, input logic [63:0] a);
    int exp_n;
    int exp_k;
    int busy_n;
    exp_n = ref_res(op, w, a);
    exp_k = ref_lat(op, w, exp_n);
    @(negedge clk);
    Start = 1'b1; Op = op; W64 = w; A = a;
    @(negedge clk);
    Start = 1'b0;
    A = {$urandom, $urandom};
    wait_done(busy_n);
    check_eq({tag, "_done"}, 64'(Done), 64'd1);
    check_eq({tag, "_latency"}, 64'(busy_n), 64'(exp_k));
    check_eq({tag, "_result"}, Result, 64'(exp_n));
    check_eq({tag, "_busy_in_done"}, 64'(Busy), 64'd0);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 64'(Done), 64'd0);
  endtask

  initial begin
    int d0;
    int busy_n;
    int sel;
    logic [63:0] one;
    logic [63:0] ra;
    n_vec = 0; n_err = 0; done_cnt = 0;
    reset = 1'b1; Start = 1'b0; Op = 2'b00; W64 = 1'b0; A = '0; Flush = 1'b0;
    one = 64'h1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("reset_busy", 64'(Busy), 64'd0);
    check_eq("reset_done", 64'(Done), 64'd0);
    check_eq("reset_result", Result, 64'd0);

    // Scenario 1: CLZ, 6 RUN cycles, 43.
    do_op("clz_bit20", 2'b00, 1'b0, 64'h0000_0000_0010_0000);

    // Scenario 4: Flush during a CPOP run; Start alongside it is dropped.
    d0 = done_cnt;
    @(negedge clk);
    Start = 1'b1; Op = 2'b10; W64 = 1'b0; A = '1;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    check_eq("flush_pre_busy", 64'(Busy), 64'd1);
    Flush = 1'b1; Start = 1'b1;
    @(negedge clk);
    Flush = 1'b0; Start = 1'b0;
    check_eq("flush_busy", 64'(Busy), 64'd0);
    check_eq("flush_done", 64'(Done), 64'd0);
    repeat (12) @(negedge clk);
    check_eq("flush_no_done", 64'(done_cnt - d0), 64'd0);
    check_eq("flush_result_kept", Result, 64'd43);
    Start = 1'b1; Flush = 1'b1;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    check_eq("flush_blocks_start", 64'(Busy), 64'd0);

    // Scenarios 2 and 3.
    do_op("cpop_ones", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op("cpop_word", 2'b10, 1'b1, 64'hFFFF_FFFF_0000_000F);
    do_op("ctz_bit7", 2'b01, 1'b0, 64'h0000_0000_0000_0080);
    do_op("ctz_word_zero", 2'b01, 1'b1, 64'h0);
    do_op("clz_zero", 2'b00, 1'b0, 64'h0);
    do_op("rsvd_as_cpop", 2'b11, 1'b0, 64'h0123_4567_89AB_CDEF);

    // Scenario 5: asynchronous reset mid-RUN.
    @(negedge clk);
    Start = 1'b1; Op = 2'b10; W64 = 1'b0; A = '1;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check_eq("async_rst_busy", 64'(Busy), 64'd0);
    check_eq("async_rst_done", 64'(Done), 64'd0);
    check_eq("async_rst_result", Result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op("post_reset_clz", 2'b00, 1'b0, 64'h0000_0100_0000_0000);

    // Scenario 6: Start pulsed while Busy is ignored; Start held in DONE
    // is accepted with no IDLE gap.
    d0 = done_cnt;
    @(negedge clk);
    Start = 1'b1; Op = 2'b00; W64 = 1'b0; A = 64'h0001_0000_0000_0000;
    @(negedge clk);
    Op = 2'b01; A = 64'h1;
    check_eq("b2b_busy_t1", 64'(Busy), 64'd1);
    @(negedge clk);
    Start = 1'b0;
    check_eq("b2b_busy_t2", 64'(Busy), 64'd1);
    @(negedge clk);
    check_eq("b2b_done_first", 64'(Done), 64'd1);
    check_eq("b2b_result_first", Result, 64'd15);
    Start = 1'b1; Op = 2'b10; W64 = 1'b0; A = '1;
    @(negedge clk);
    Start = 1'b0;
    check_eq("b2b_no_gap_busy", 64'(Busy), 64'd1);
    check_eq("b2b_no_gap_done", 64'(Done), 64'd0);
    wait_done(busy_n);
    check_eq("b2b_second_done", 64'(Done), 64'd1);
    check_eq("b2b_second_latency", 64'(busy_n), 64'd8);
    check_eq("b2b_second_result", Result, 64'd64);
    @(negedge clk);
    check_eq("b2b_done_count", 64'(done_cnt - d0), 64'd2);

    // Randomized operations.
    for (int t = 0; t < 250; t++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: ra = {$urandom, $urandom};
        1: ra = one << $urandom_range(0, 63);
        2: ra = '0;
        3: ra = {$urandom, $urandom} >> $urandom_range(0, 63);
        default: ra = {$urandom, $urandom} << $urandom_range(0, 63);
      endcase
      do_op("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
